ram_arbiter: RTL and testbench

- Shares one single-port Ram (combinational read, synchronous write) between two requesters: port 0 (CPU) and port 1 (loader/DMA).
- Makes at most one RAM access per cycle and returns read data registered, one cycle after the grant.
- Supports per-port bus lock for short bursts, bounded by MAX_HOLD so the other port cannot starve.
- Sits between the CPU/loader and the Ram instance; it is the only driver of the Ram's enable, addr and data_in.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arb_pick.sv | 56 +++++
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Tie policy is selected by RAM_ARB_RR_EN (see ram_arb_pick).
package ram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        OWN0 = ST_OWN0,
        OWN1 = ST_OWN1
    } state_t;

    // Hold counter width; never zero, even when MAX_HOLD is 1.
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection: lock retention, bounded hold, tie rule.
// RAM_ARB_RR_EN defined: round-robin ties; undefined: port 0 wins ties.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HW       = hold_width(MAX_HOLD)
) (
    input  state_t        state,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [HW-1:0] hold_cnt,
    input  logic          last_owner,
    output logic          gnt0,
    output logic          gnt1
);

    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    logic keep0;
    logic keep1;
    logic tie_to0;

    assign keep0 = (state == OWN0) && req0 && lock0;
    assign keep1 = (state == OWN1) && req1 && lock1;

`ifdef RAM_ARB_RR_EN
    assign tie_to0 = (last_owner == P1);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign tie_to0           = 1'b1;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // An exhausted lock hands exactly one access to the waiting port.
        if (keep0) begin
            if (!req1 || (hold_cnt < HOLD_LIM)) gnt0 = 1'b1;
            else                                gnt1 = 1'b1;
        end else if (keep1) begin
            if (!req0 || (hold_cnt < HOLD_LIM)) gnt1 = 1'b1;
            else                                gnt0 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = tie_to0;
            gnt1 = !tie_to0;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: one access per cycle,
// registered read return, bounded bus lock. Tie policy: RAM_ARB_RR_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int D        = 8,
    parameter int A        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0,
    input  logic         we0,
    input  logic         lock0,
    input  logic [A-1:0] addr0,
    input  logic [D-1:0] wdata0,
    output logic         ack0,
    output logic [D-1:0] rdata0,
    output logic         rvalid0,

    input  logic         req1,
    input  logic         we1,
    input  logic         lock1,
    input  logic [A-1:0] addr1,
    input  logic [D-1:0] wdata1,
    output logic         ack1,
    output logic [D-1:0] rdata1,
    output logic         rvalid1,

    output logic         ram_enable,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_data_in,
    input  logic [D-1:0] ram_data_out
);

    localparam int              HW       = hold_width(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD - 1);

    state_t        state;
    state_t        state_nxt;
    logic          last_owner;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic          gnt0;
    logic          gnt1;

    ram_arb_pick #(
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) u_pick (
        .state      (state),
        .req0       (req0),
        .req1       (req1),
        .lock0      (lock0),
        .lock1      (lock1),
        .hold_cnt   (hold_cnt),
        .last_owner (last_owner),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // Reset gates grants combinationally so nothing reaches the RAM.
    assign ack0 = gnt0 & ~rst;
    assign ack1 = gnt1 & ~rst;

    always_comb begin
        ram_enable  = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        if (ack0) begin
            ram_enable  = we0;
            ram_addr    = addr0;
            ram_data_in = wdata0;
        end else if (ack1) begin
            ram_enable  = we1;
            ram_addr    = addr1;
            ram_data_in = wdata1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        if (ack0) begin
            state_nxt = OWN0;
            if (state == OWN0 && lock0)
                hold_nxt = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;
        end else if (ack1) begin
            state_nxt = OWN1;
            if (state == OWN1 && lock1)
                hold_nxt = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= P1;
            hold_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (ack0)      last_owner <= P0;
            else if (ack1) last_owner <= P1;
        end
    end

    // Read return: capture at the grant edge, valid for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= ack0 & ~we0;
            rvalid1 <= ack1 & ~we1;
            if (ack0 && !we0) rdata0 <= ram_data_out;
            if (ack1 && !we1) rdata1 <= ram_data_out;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed checks of ram_arbiter against a rule-level model.
// Build with or without RAM_ARB_RR_EN; the model follows the same define.
module tb_ram_arbiter;

    localparam int D        = 8;
    localparam int A        = 8;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
    logic [A-1:0] addr0 = '0, addr1 = '0;
    logic [D-1:0] wdata0 = '0, wdata1 = '0;
    logic         ack0, ack1, rvalid0, rvalid1, ram_enable;
    logic [D-1:0] rdata0, rdata1, ram_data_in, ram_data_out;
    logic [A-1:0] ram_addr;

    logic [D-1:0] ram [2**A];

    always #5 clk = ~clk;

    ram_arbiter #(.D(D), .A(A), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ram_enable(ram_enable), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // RAM: combinational read, synchronous write.
    assign ram_data_out = ram[ram_addr];
    initial begin
        for (int i = 0; i < 2**A; i++) ram[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(posedge clk);
            if (ram_enable) ram[ram_addr] <= ram_data_in;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: owner of the previous cycle (-1 = none), length of the current
    // locked run, last granted port, a shadow memory and expected read return.
    int           owner, streak, last;
    logic [D-1:0] ref_mem [2**A];
    logic [1:0]   exp_rv;
    logic [D-1:0] exp_rd [2];

    logic [1:0]   c_rq, c_lk, c_wr;
    logic [A-1:0] c_ad [2];
    logic [D-1:0] c_wd [2];
    int           last_g;
    logic         seen0, seen1;

    task automatic model_reset();
        owner  = -1;
        streak = 0;
        last   = 1;
        exp_rv = 2'b00;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    function automatic int model_grant(input logic [1:0] rq, input logic [1:0] lk);
        int o;
        if (rst) return -1;
        if (owner >= 0 && rq[owner] && lk[owner]) begin
            o = 1 - owner;
            return (!rq[o] || streak < MAX_HOLD) ? owner : o;
        end
        if (rq == 2'b11) begin
`ifdef RAM_ARB_RR_EN
            return 1 - last;
`else
            return 0;
`endif
        end
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    task automatic check_cycle();
        int i;
        @(negedge clk);
        c_rq = {req1, req0};
        c_lk = {lock1, lock0};
        c_wr = {we1, we0};
        c_ad[0] = addr0;  c_ad[1] = addr1;
        c_wd[0] = wdata0; c_wd[1] = wdata1;
        last_g = model_grant(c_rq, c_lk);
        seen0 = ack0;
        seen1 = ack1;
        i = (last_g < 0) ? 0 : last_g;
        chk("ack0", 32'(ack0), 32'(last_g == 0));
        chk("ack1", 32'(ack1), 32'(last_g == 1));
        chk("ram_enable", 32'(ram_enable), 32'(last_g >= 0 && c_wr[i]));
        chk("ram_addr", 32'(ram_addr), (last_g >= 0) ? 32'(c_ad[i]) : 32'd0);
        chk("ram_data_in", 32'(ram_data_in), (last_g >= 0) ? 32'(c_wd[i]) : 32'd0);
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
        chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    endtask

    task automatic commit();
        exp_rv = 2'b00;
        if (last_g >= 0) begin
            if (c_wr[last_g]) begin
                ref_mem[c_ad[last_g]] = c_wd[last_g];
            end else begin
                exp_rv[last_g] = 1'b1;
                exp_rd[last_g] = ref_mem[c_ad[last_g]];
            end
            streak = (last_g == owner && c_lk[last_g]) ? streak + 1 : 1;
            last   = last_g;
        end else begin
            streak = 0;
        end
        owner = last_g;
    endtask

    task automatic step();
        check_cycle();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic reset_phase(input int n);
        rst = 1'b1;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_ack0", 32'(ack0), 32'd0);
            chk("rst_ack1", 32'(ack1), 32'd0);
            chk("rst_ram_enable", 32'(ram_enable), 32'd0);
            chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
            chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [A-1:0] a, input logic [D-1:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [A-1:0] a, input logic [D-1:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    int cnt0, cnt1;
    int pat3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic took0, took1;

    initial begin
        for (int i = 0; i < 2**A; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        model_reset();
        reset_phase(2);

        // Single write then read on port 0.
        set0(1, 1, 0, 8'h10, 8'hA5);
        step();
        chk("t1_wr_ack0", 32'(seen0), 32'd1);
        set0(1, 0, 0, 8'h10, 8'h00);
        step();
        chk("t1_rvalid0", 32'(rvalid0), 32'd1);
        chk("t1_rdata0", 32'(rdata0), 32'hA5);
        set0(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("t1_rvalid0_pulse", 32'(rvalid0), 32'd0);

        // Continuous tie without locks.
        cnt0 = 0; cnt1 = 0;
        set0(1, 0, 0, 8'h03, 8'h00);
        set1(1, 0, 0, 8'h04, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
            cnt0 += int'(seen0);
            cnt1 += int'(seen1);
        end
`ifdef RAM_ARB_RR_EN
        chk("t2_cnt0", 32'(cnt0), 32'd4);
        chk("t2_cnt1", 32'(cnt1), 32'd4);
`else
        chk("t2_cnt0", 32'(cnt0), 32'd8);
        chk("t2_cnt1", 32'(cnt1), 32'd0);
`endif

        // Lock bound: four locked grants, one forced grant to port 1.
        reset_phase(1);
        set0(1, 0, 1, 8'h05, 8'h00);
        set1(1, 0, 0, 8'h06, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_ack1", 32'(seen1), 32'(pat3[i]));
        end

        // Uncontested lock on port 1.
        set0(0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            set1(1, 1, 1, 8'(8'h30 + i), 8'($urandom));
            step();
            chk("t4_ack1", 32'(seen1), 32'd1);
        end

        // Reset during a port 1 read; port 0 write presented under reset.
        set1(1, 0, 0, 8'h10, 8'h00);
        step();
        chk("t5_first_rdata1", 32'(rdata1), 32'hA5);
        set1(1, 0, 0, 8'h10, 8'h00);
        check_cycle();
        chk("t5_ack1", 32'(seen1), 32'd1);
        #2;
        rst = 1'b1;
        set0(1, 1, 0, 8'h20, 8'hFF);
        reset_phase(3);
        set0(0, 0, 0, 8'h00, 8'h00);
        set1(0, 0, 0, 8'h00, 8'h00);
        step();
        chk("t5_rvalid1", 32'(rvalid1), 32'd0);
        chk("t5_rdata1", 32'(rdata1), 32'd0);
        set0(1, 0, 0, 8'h20, 8'h00);
        step();
        chk("t6_rdata0", 32'(rdata0), 32'h7A);

        // Random traffic; requesters hold their request until acknowledged.
        set0(0, 0, 0, 8'h00, 8'h00);
        took0 = 1'b1;
        took1 = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!req0 || took0)
                set0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0,
                     8'($urandom_range(0, 15)), 8'($urandom));
            if (!req1 || took1)
                set1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0,
                     8'($urandom_range(0, 15)), 8'($urandom));
            lock0 = ($urandom_range(0, 3) != 0);
            lock1 = ($urandom_range(0, 3) != 0);
            step();
            took0 = (last_g == 0);
            took1 = (last_g == 1);
            if ($urandom_range(0, 199) == 0) begin
                reset_phase(1);
                took0 = 1'b1;
                took1 = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
